// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// alu_operand_stage : resolves ALU operands (r0, EX/WB forwarding, immediate)
//                     into a main output register backed by one skid entry.
// Revision 1.0
// ============================================================================
module alu_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_oper,
  input  logic [REG_IDX_WIDTH-1:0] in_ra,
  input  logic [REG_IDX_WIDTH-1:0] in_rb,
  input  logic [REG_IDX_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0]    in_ra_data,
  input  logic [DATA_WIDTH-1:0]    in_rb_data,
  input  logic [15:0]              in_imm,
  input  logic                     in_use_imm,
  input  logic                     in_imm_signed,

  input  logic                     fwd_ex_valid,
  input  logic [REG_IDX_WIDTH-1:0] fwd_ex_rd,
  input  logic [DATA_WIDTH-1:0]    fwd_ex_data,
  input  logic                     fwd_wb_valid,
  input  logic [REG_IDX_WIDTH-1:0] fwd_wb_rd,
  input  logic [DATA_WIDTH-1:0]    fwd_wb_data,

  input  logic                     flush,

  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_oper,
  output logic [DATA_WIDTH-1:0]    out_a,
  output logic [DATA_WIDTH-1:0]    out_b,
  output logic [REG_IDX_WIDTH-1:0] out_rd
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]               oper;
    logic [DATA_WIDTH-1:0]    a;
    logic [DATA_WIDTH-1:0]    b;
    logic [REG_IDX_WIDTH-1:0] rd;
  } entry_t;

  state_t                  state_q, state_d;
  entry_t                  main_q, main_d;
  entry_t                  skid_q, skid_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;

  logic                    acc, con;
  logic                    ex_hit_a, wb_hit_a, ex_hit_b, wb_hit_b;
  logic [DATA_WIDTH-1:0]   res_a, res_b, imm_ext;
  entry_t                  new_entry;

  assign acc = in_valid && in_ready_q;
  assign con = out_valid_q && out_ready;

  // A forward entry targeting r0 can never hit because r0 short-circuits first.
  assign ex_hit_a = fwd_ex_valid && (fwd_ex_rd == in_ra);
  assign wb_hit_a = fwd_wb_valid && (fwd_wb_rd == in_ra);
  assign ex_hit_b = fwd_ex_valid && (fwd_ex_rd == in_rb);
  assign wb_hit_b = fwd_wb_valid && (fwd_wb_rd == in_rb);

  assign imm_ext = in_imm_signed ? {{(DATA_WIDTH-16){in_imm[15]}}, in_imm}
                                 : {{(DATA_WIDTH-16){1'b0}}, in_imm};

  always_comb begin
    res_a = in_ra_data;
    if (in_ra == '0) begin
      res_a = '0;
    end else if (ex_hit_a) begin
      res_a = fwd_ex_data;
    end else if (wb_hit_a) begin
      res_a = fwd_wb_data;
    end
  end

  always_comb begin
    res_b = in_rb_data;
    if (in_use_imm) begin
      res_b = imm_ext;
    end else if (in_rb == '0) begin
      res_b = '0;
    end else if (ex_hit_b) begin
      res_b = fwd_ex_data;
    end else if (wb_hit_b) begin
      res_b = fwd_wb_data;
    end
  end

  always_comb begin
    new_entry      = '0;
    new_entry.oper = in_oper;
    new_entry.a    = res_a;
    new_entry.b    = res_b;
    new_entry.rd   = in_rd;
  end

  // Empty entries are held at zero so the outputs read 0 whenever invalid.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            main_d  = new_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && con) begin
            main_d = new_entry;
          end else if (acc) begin
            skid_d  = new_entry;
            state_d = ST_FULL;
          end else if (con) begin
            main_d  = '0;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (con) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_oper  = main_q.oper;
  assign out_a     = main_q.a;
  assign out_b     = main_q.b;
  assign out_rd    = main_q.rd;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_operand_stage : directed + random checks against a queue-based model.
// Revision 1.0
// ============================================================================
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_oper;
  logic [3:0]  in_ra, in_rb, in_rd;
  logic [31:0] in_ra_data, in_rb_data;
  logic [15:0] in_imm;
  logic        in_use_imm, in_imm_signed;
  logic        fwd_ex_valid, fwd_wb_valid;
  logic [3:0]  fwd_ex_rd, fwd_wb_rd;
  logic [31:0] fwd_ex_data, fwd_wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [3:0]  out_oper, out_rd;
  logic [31:0] out_a, out_b;

  typedef struct packed {
    logic [3:0]  oper;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
  } item_t;

  item_t q[$];
  int    total = 0;
  int    bad   = 0;

  alu_operand_stage #(.DATA_WIDTH(32), .REG_IDX_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_oper(in_oper),
    .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
    .in_ra_data(in_ra_data), .in_rb_data(in_rb_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_imm_signed(in_imm_signed),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_oper(out_oper),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_src(input logic [3:0] idx, input logic [31:0] rf);
    if (idx == 4'd0) return 32'd0;
    if (fwd_ex_valid && fwd_ex_rd != 4'd0 && fwd_ex_rd == idx) return fwd_ex_data;
    if (fwd_wb_valid && fwd_wb_rd != 4'd0 && fwd_wb_rd == idx) return fwd_wb_data;
    return rf;
  endfunction

  // Model: the stage is a 2-deep in-order queue; head is what the ALU sees.
  task automatic check_outputs();
    item_t e;
    e = (q.size() != 0) ? q[0] : '0;
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("out_oper", {28'd0, out_oper}, {28'd0, e.oper});
    chk("out_a", out_a, e.a);
    chk("out_b", out_b, e.b);
    chk("out_rd", {28'd0, out_rd}, {28'd0, e.rd});
  endtask

  task automatic cycle();
    item_t it;
    logic acc, con;
    logic signed [31:0] sx;
    acc = in_valid && in_ready;
    con = out_valid && out_ready;
    sx  = $signed(in_imm);
    it.oper = in_oper;
    it.rd   = in_rd;
    it.a    = ref_src(in_ra, in_ra_data);
    it.b    = in_use_imm ? (in_imm_signed ? $unsigned(sx) : {16'h0, in_imm})
                         : ref_src(in_rb, in_rb_data);
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(it);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [3:0] rd, input logic [31:0] rad, input logic [31:0] rbd);
    in_oper = op; in_ra = ra; in_rb = rb; in_rd = rd;
    in_ra_data = rad; in_rb_data = rbd;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; out_ready = 0; flush = 0;
    set_instr(4'd0, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0);
    in_imm = 0; in_use_imm = 0; in_imm_signed = 0;
    fwd_ex_valid = 0; fwd_ex_rd = 0; fwd_ex_data = 0;
    fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Forwarding priority: EX over WB over register file
    out_ready = 1; in_valid = 1;
    set_instr(4'd5, 4'd3, 4'd7, 4'd9, 32'h11, 32'h77);
    fwd_ex_valid = 1; fwd_ex_rd = 3; fwd_ex_data = 32'h22;
    fwd_wb_valid = 1; fwd_wb_rd = 3; fwd_wb_data = 32'h33;
    cycle();
    chk("fwd_ex_prio", out_a, 32'h22);
    chk("first_latency", {31'd0, out_valid}, 32'd1);
    fwd_ex_valid = 0;
    cycle();
    chk("fwd_wb", out_a, 32'h33);

    // r0 and immediate extension
    set_instr(4'd6, 4'd0, 4'd1, 4'd2, 32'h99, 32'h44);
    fwd_ex_valid = 1; fwd_ex_rd = 0; fwd_ex_data = 32'h55;
    in_use_imm = 1; in_imm = 16'h8000; in_imm_signed = 1;
    cycle();
    chk("r0_zero", out_a, 32'h0);
    chk("imm_signed", out_b, 32'hFFFF8000);
    in_imm_signed = 0;
    cycle();
    chk("imm_unsigned", out_b, 32'h00008000);
    in_use_imm = 0; fwd_ex_valid = 0; fwd_wb_valid = 0;
    in_valid = 0;
    cycle();
    chk("drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: A, B accepted; C held by decode
    out_ready = 0; in_valid = 1;
    set_instr(4'd1, 4'd4, 4'd5, 4'd1, 32'hA, 32'hA0);
    cycle();
    set_instr(4'd2, 4'd4, 4'd5, 4'd2, 32'hB, 32'hB0);
    cycle();
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    set_instr(4'd3, 4'd4, 4'd5, 4'd3, 32'hC, 32'hC0);
    cycle();
    chk("bp_hold_a", {28'd0, out_oper}, 32'd1);
    out_ready = 1;
    cycle();
    chk("bp_out_b", {28'd0, out_oper}, 32'd2);
    cycle();
    chk("bp_out_c", {28'd0, out_oper}, 32'd3);
    in_valid = 0;
    cycle();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Full throughput with simultaneous transfers
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      set_instr(4'(i + 4), 4'(i), 4'(i + 1), 4'(i), 32'(i * 3), 32'(i * 5));
      cycle();
      chk("tput_in_ready", {31'd0, in_ready}, 32'd1);
      chk("tput_oper", {28'd0, out_oper}, 32'(i + 4));
    end

    // Flush in FULL with input presented
    in_valid = 0;
    cycle();
    out_ready = 0; in_valid = 1;
    cycle();
    cycle();
    chk("pre_flush_full", {31'd0, in_ready}, 32'd0);
    flush = 1;
    cycle();
    flush = 0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 0; out_ready = 1;
    cycle();
    chk("flush_nothing", {31'd0, out_valid}, 32'd0);

    // Flush in ONE discards the instruction accepted that cycle
    in_valid = 1; out_ready = 0;
    cycle();
    flush = 1;
    cycle();
    flush = 0; in_valid = 0;
    chk("flush_one_drop", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between clock edges
    in_valid = 1; out_ready = 0;
    set_instr(4'd8, 4'd2, 4'd3, 4'd4, 32'h12, 32'h34);
    cycle();
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_oper", {28'd0, out_oper}, 32'd0);
    q.delete();
    #1 rst = 0;
    in_valid = 1;
    set_instr(4'd9, 4'd1, 4'd2, 4'd3, 32'h5, 32'h6);
    cycle();
    chk("post_rst_accept", {28'd0, out_oper}, 32'd9);

    // Random traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      in_valid      = 1'($urandom_range(0, 1));
      out_ready     = 1'($urandom_range(0, 1));
      flush         = ($urandom_range(0, 31) == 0);
      set_instr(4'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                4'($urandom), $urandom, $urandom);
      in_imm        = 16'($urandom);
      in_use_imm    = 1'($urandom_range(0, 1));
      in_imm_signed = 1'($urandom_range(0, 1));
      fwd_ex_valid  = 1'($urandom_range(0, 1));
      fwd_ex_rd     = 4'($urandom_range(0, 3));
      fwd_ex_data   = $urandom;
      fwd_wb_valid  = 1'($urandom_range(0, 1));
      fwd_wb_rd     = 4'($urandom_range(0, 3));
      fwd_wb_data   = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Parameters
REQ-001 Parameter DATA_WIDTH, default 32: width of register data and ALU operands.
REQ-002 Parameter REG_IDX_WIDTH, default 4: register index width; 16 registers, r0 reads as zero.

Interface
REQ-003 clk  in  1  Sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  Reset; asynchronous, active-high.
REQ-005 in_valid  in  1  Decode presents an instruction.
REQ-006 in_ready  out  1  Stage accepts; a transfer occurs when in_valid and in_ready are both 1.
REQ-007 in_oper  in  4  ALU operation code, passed through unchanged.
REQ-008 in_ra, in_rb, in_rd  in  REG_IDX_WIDTH each  Source A, source B and destination indices.
REQ-009 in_ra_data, in_rb_data  in  DATA_WIDTH each  Register-file read values.
REQ-010 in_imm  in  16  Immediate.
REQ-011 in_use_imm  in  1  1 = operand B from the immediate.
REQ-012 in_imm_signed  in  1  1 = sign-extend the immediate; 0 = zero-extend it.
REQ-013 fwd_ex_valid, fwd_ex_rd, fwd_ex_data  in  1/REG_IDX_WIDTH/DATA_WIDTH  Result of the nearest older instruction.
REQ-014 fwd_wb_valid, fwd_wb_rd, fwd_wb_data  in  1/REG_IDX_WIDTH/DATA_WIDTH  Result of the second-nearest older instruction.
REQ-015 flush  in  1  Discard all held instructions.
REQ-016 out_valid  out  1  The ALU input holds a valid instruction.
REQ-017 out_ready  in  1  Downstream consumes; a transfer occurs when out_valid and out_ready are both 1.
REQ-018 out_oper, out_a, out_b, out_rd  out  4/DATA_WIDTH/DATA_WIDTH/REG_IDX_WIDTH  Registered ALU operation, operands and destination.

Function
REQ-019 Operand A resolution priority at capture:
  - ra == 0 -> 0;
  - else fwd_ex_valid and fwd_ex_rd == ra -> fwd_ex_data;
  - else fwd_wb_valid and fwd_wb_rd == ra -> fwd_wb_data;
  - else in_ra_data.
REQ-020 Operand B uses the same resolution with rb, unless in_use_imm = 1, in which case B is the extended immediate and forwarding is ignored.
REQ-021 Forward entries with rd == 0 never match.
REQ-022 Operands are resolved only in the transfer cycle; held entries never re-resolve.
REQ-023 Storage is a main output register plus one skid register. States:
  - EMPTY: main and skid both invalid;
  - ONE: main valid, skid invalid;
  - FULL: main and skid both valid.
REQ-024 in_ready SHALL be a registered signal equal to (state != FULL).
REQ-025 State transitions (acc = input transfer, con = output transfer):
  - EMPTY, acc -> ONE;
  - ONE, acc and con -> ONE, main loads the new instruction;
  - ONE, acc only -> FULL, the new instruction goes to skid;
  - ONE, con only -> EMPTY;
  - FULL, con -> ONE, skid moves to main.
REQ-026 In FULL no input transfer is possible, because in_ready = 0.
REQ-027 Order is strictly preserved; no instruction is dropped or duplicated.
REQ-028 Latency: one cycle from input transfer to out_valid when the stage is EMPTY or the main entry is being consumed in the same cycle.
REQ-029 out_* fields stay stable while out_valid = 1 and out_ready = 0.
REQ-030 flush = 1 forces EMPTY at the next edge, has priority over any simultaneous transfer, and the instruction accepted in that cycle is discarded; in_ready = 1 the following cycle.
REQ-031 out_oper, out_a, out_b and out_rd SHALL be 0 whenever out_valid = 0.

Reset
REQ-032 rst asserted asynchronously forces EMPTY immediately: out_valid = 0, all out_* fields = 0, in_ready = 1, skid cleared.
REQ-033 Reset asserted mid-operation discards held instructions without completing them.
REQ-034 The first transfer is possible on the first rising edge after rst deasserts.

Verification
REQ-035 Forward priority: ra = 3, in_ra_data = 0x11, fwd_ex (3, 0x22), fwd_wb (3, 0x33) -> out_a = 0x22; with fwd_ex_valid = 0 -> out_a = 0x33.
REQ-036 r0 and immediate:
  - ra = 0 with fwd_ex_rd = 0, data 0x55 -> out_a = 0;
  - in_use_imm = 1, imm = 0x8000, signed -> out_b = 0xFFFF8000; unsigned -> out_b = 0x00008000.
REQ-037 Backpressure: out_ready = 0, three consecutive in_valid instructions A, B, C -> A and B accepted, in_ready = 0 the cycle after B; C is held by decode. Release out_ready -> outputs A, B, C in order, one per cycle.
REQ-038 Simultaneous transfer: in state ONE with in_valid = 1 and out_ready = 1 every cycle -> full throughput, in_ready stays 1, no bubbles.
REQ-039 Flush and reset:
  - flush in FULL with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, nothing emitted;
  - rst pulse between clock edges in ONE -> out_valid = 0 immediately, without waiting for a clock edge.
